// File: rtl/dmac_xfer_engine.sv
// Single-channel DMA transfer engine: moves op_size 32-bit words as read/write bus pairs.
// Optional abort support is enabled by defining DMAC_ABORT_EN.
module dmac_xfer_engine #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_start,
  input  logic [31:0]      op_src,
  input  logic [31:0]      op_dst,
  input  logic [CNT_W-1:0] op_size,
  output logic             m_req,
  input  logic             m_grant,
  output logic             m_wr,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_dout,
  input  logic [31:0]      m_din,
  output logic             busy,
  output logic             done,
  output logic             irq,
  input  logic             irq_clr,
`ifdef DMAC_ABORT_EN
  input  logic             op_abort,
  output logic             aborted,
`endif
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [31:0]      data_buf;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             irq_q;
  logic             abort_hit;

  assign cnt_inc = cnt_q + CNT_W'(1);

`ifdef DMAC_ABORT_EN
  assign abort_hit = op_abort && ((state_q == S_RD) || (state_q == S_WR));
`else
  assign abort_hit = 1'b0;
`endif

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the values from before the clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    m_req   = 1'b0;
    m_wr    = 1'b0;
    m_addr  = 32'h0;
    m_dout  = 32'h0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (op_start) state_d = (op_size == '0) ? S_DONE : S_RD;
      end
      S_RD: begin
        m_req  = 1'b1;
        m_addr = src_ptr;
        busy   = 1'b1;
        if (abort_hit)    state_d = S_DONE;
        else if (m_grant) state_d = S_WR;
      end
      S_WR: begin
        m_req  = 1'b1;
        m_wr   = 1'b1;
        m_addr = dst_ptr;
        m_dout = data_buf;
        busy   = 1'b1;
        if (abort_hit)    state_d = S_DONE;
        else if (m_grant) state_d = (cnt_inc == len) ? S_DONE : S_RD;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A bus transaction that completes in the same cycle as an abort is still
  // honoured, so the datapath ignores abort_hit entirely.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_ptr  <= 32'h0;
      dst_ptr  <= 32'h0;
      data_buf <= 32'h0;
      len      <= '0;
      cnt_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (op_start) begin
            src_ptr <= op_src;
            dst_ptr <= op_dst;
            len     <= op_size;
            cnt_q   <= '0;
          end
        end
        S_RD: begin
          if (m_grant) data_buf <= m_din;
        end
        S_WR: begin
          if (m_grant) begin
            src_ptr <= src_ptr + 32'd4;
            dst_ptr <= dst_ptr + 32'd4;
            cnt_q   <= cnt_inc;
          end
        end
        default: ;
      endcase
      // Set has priority over a coincident clear.
      if (state_q == S_DONE) irq_q <= 1'b1;
      else if (irq_clr)      irq_q <= 1'b0;
    end
  end

`ifdef DMAC_ABORT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aborted <= 1'b0;
    end else if ((state_q == S_IDLE) && op_start) begin
      aborted <= 1'b0;
    end else if (abort_hit) begin
      aborted <= 1'b1;
    end
  end
`endif

  assign irq      = irq_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_dmac_xfer_engine.sv
// Self-checking bench for dmac_xfer_engine: directed and randomized transfers
// compared against a transaction-level model; abort cases when DMAC_ABORT_EN is defined.
module tb_dmac_xfer_engine;

  logic        clk;
  logic        reset_n;
  logic        op_start;
  logic [31:0] op_src;
  logic [31:0] op_dst;
  logic [15:0] op_size;
  logic        m_req;
  logic        m_grant;
  logic        m_wr;
  logic [31:0] m_addr;
  logic [31:0] m_dout;
  logic [31:0] m_din;
  logic        busy;
  logic        done;
  logic        irq;
  logic        irq_clr;
  logic [15:0] xfer_cnt;
`ifdef DMAC_ABORT_EN
  logic        op_abort;
  logic        aborted;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] seed;

  dmac_xfer_engine #(.CNT_W(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op_start (op_start),
    .op_src   (op_src),
    .op_dst   (op_dst),
    .op_size  (op_size),
    .m_req    (m_req),
    .m_grant  (m_grant),
    .m_wr     (m_wr),
    .m_addr   (m_addr),
    .m_dout   (m_dout),
    .m_din    (m_din),
    .busy     (busy),
    .done     (done),
    .irq      (irq),
    .irq_clr  (irq_clr),
`ifdef DMAC_ABORT_EN
    .op_abort (op_abort),
    .aborted  (aborted),
`endif
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Source memory contents are a fixed hash of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A50F0F ^ seed;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; outputs are sampled and inputs driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_m_req"},  {31'h0, m_req},  32'h0);
    check({tag, "_m_wr"},   {31'h0, m_wr},   32'h0);
    check({tag, "_m_addr"}, m_addr,          32'h0);
    check({tag, "_m_dout"}, m_dout,          32'h0);
    check({tag, "_busy"},   {31'h0, busy},   32'h0);
  endtask

  // mode 0: grant always; mode 1: each read withheld 3 cycles; mode 2: random grant.
  task automatic run_xfer(input string tag, input logic [31:0] src, input logic [31:0] dst,
                          input logic [15:0] size, input int mode,
                          input bit restart_mid, input bit clr_at_done);
    logic [31:0] exp_addr[$];
    bit          exp_wr[$];
    logic [31:0] exp_data[$];
    int          waits;
    int          cyc;
    int          wait_left;
    int          exp_done;
    bit          seen_done;
    bit          grant;
    for (int i = 0; i < int'(size); i++) begin
      logic [31:0] ra;
      logic [31:0] wa;
      ra = src + 32'(4 * i);
      wa = dst + 32'(4 * i);
      exp_addr.push_back(ra); exp_wr.push_back(1'b0); exp_data.push_back(32'h0);
      exp_addr.push_back(wa); exp_wr.push_back(1'b1); exp_data.push_back(mem_fn(ra));
    end
    waits     = 0;
    seen_done = 1'b0;
    wait_left = (mode == 1) ? 3 : 0;
    op_src = src; op_dst = dst; op_size = size; op_start = 1'b1; m_grant = 1'b0;
    tick();
    op_start = 1'b0;
    check({tag, "_cnt_clear"}, {16'h0, xfer_cnt}, 32'h0);
    cyc = 1;
    while (!seen_done && cyc <= 400) begin
      op_start = (restart_mid && cyc == 3);
      if (op_start) begin
        op_src = 32'hDEAD0000; op_dst = 32'hBEEF0000; op_size = 16'd9;
      end
      grant   = 1'b0;
      irq_clr = 1'b0;
      if (m_req) begin
        if (exp_addr.size() == 0) begin
          check({tag, "_extra_req"}, {31'h0, m_req}, 32'h0);
        end else begin
          check({tag, "_addr"}, m_addr, exp_addr[0]);
          check({tag, "_wr"}, {31'h0, m_wr}, {31'h0, exp_wr[0]});
          if (exp_wr[0]) check({tag, "_wdata"}, m_dout, exp_data[0]);
          if (mode == 0) grant = 1'b1;
          else if (mode == 1) begin
            if (exp_wr[0]) grant = 1'b1;
            else if (wait_left > 0) wait_left--;
            else begin
              grant = 1'b1;
              wait_left = 3;
            end
          end else grant = ($urandom_range(0, 2) != 0);
          if (grant) begin
            void'(exp_addr.pop_front()); void'(exp_wr.pop_front()); void'(exp_data.pop_front());
          end else waits++;
        end
        m_din = m_wr ? $urandom : mem_fn(m_addr);
      end else if (!done) begin
        check({tag, "_idle_addr"}, m_addr, 32'h0);
      end
      if (done) begin
        seen_done = 1'b1;
        exp_done  = (size == 0) ? 1 : 2 * int'(size) + 1 + waits;
        check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_done));
        check({tag, "_left_txn"}, 32'(exp_addr.size()), 32'h0);
        check({tag, "_xfer_cnt"}, {16'h0, xfer_cnt}, {16'h0, size});
        check_idle_outputs({tag, "_done"});
        irq_clr = clr_at_done;
      end
      m_grant = grant;
      tick();
      cyc++;
    end
    if (!seen_done) check({tag, "_done_timeout"}, 32'(cyc), 32'h0);
    op_start = 1'b0;
    irq_clr  = 1'b0;
    m_grant  = 1'b0;
    check({tag, "_irq"}, {31'h0, irq}, 32'h1);
    check({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
    check_idle_outputs({tag, "_after"});
  endtask

  initial begin
    seed     = $urandom;
    reset_n  = 1'b0;
    op_start = 1'b0;
    op_src   = 32'h0;
    op_dst   = 32'h0;
    op_size  = 16'h0;
    m_grant  = 1'b0;
    m_din    = 32'h0;
    irq_clr  = 1'b0;
`ifdef DMAC_ABORT_EN
    op_abort = 1'b0;
`endif
    repeat (3) tick();
    check_idle_outputs("rst");
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_cnt", {16'h0, xfer_cnt}, 32'h0);
    reset_n = 1'b1;
    tick();

    run_xfer("basic3", 32'h00001000, 32'h00002000, 16'd3, 0, 1'b0, 1'b0);
    tick();
    run_xfer("size0", 32'h00005000, 32'h00006000, 16'd0, 0, 1'b0, 1'b0);
    run_xfer("wait2", 32'h00007000, 32'h00008000, 16'd2, 1, 1'b1, 1'b0);
    run_xfer("wrap", 32'hFFFFFFFC, 32'h00009000, 16'd2, 0, 1'b0, 1'b1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check("irq_cleared", {31'h0, irq}, 32'h0);

    for (int k = 0; k < 5; k++) begin
      run_xfer("rand", $urandom, $urandom, 16'($urandom_range(1, 6)), 2, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset during the write of word 2 of 4: cycles RD1, WR1, RD2, WR2.
    op_src = 32'h0000A000; op_dst = 32'h0000B000; op_size = 16'd4; op_start = 1'b1;
    m_grant = 1'b1;
    tick();
    op_start = 1'b0;
    repeat (3) tick();
    check("rst_mid_in_wr2", m_addr, 32'h0000B004);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    check("rst_mid_cnt", {16'h0, xfer_cnt}, 32'h0);
    check("rst_mid_irq", {31'h0, irq}, 32'h0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rst_mid_no_done", {31'h0, done}, 32'h0);
      check("rst_mid_no_req", {31'h0, m_req}, 32'h0);
    end
    check("rst_mid_no_irq", {31'h0, irq}, 32'h0);
    m_grant = 1'b0;

`ifdef DMAC_ABORT_EN
    // Abort in RD of word 3 without grant.
    op_src = 32'h00003000; op_dst = 32'h00004000; op_size = 16'd5; op_start = 1'b1;
    m_grant = 1'b1;
    tick();
    op_start = 1'b0;
    repeat (4) tick();
    check("abort_rd_addr", m_addr, 32'h00003008);
    m_grant = 1'b0; op_abort = 1'b1;
    tick();
    op_abort = 1'b0;
    check("abort_rd_done", {31'h0, done}, 32'h1);
    check("abort_rd_cnt", {16'h0, xfer_cnt}, 32'h2);
    check("abort_rd_flag", {31'h0, aborted}, 32'h1);
    tick();
    check("abort_rd_irq", {31'h0, irq}, 32'h1);
    // Abort coinciding with WR grant of word 3.
    op_start = 1'b1; m_grant = 1'b1;
    tick();
    op_start = 1'b0;
    check("abort_flag_clr", {31'h0, aborted}, 32'h0);
    repeat (5) tick();
    check("abort_wr_addr", m_addr, 32'h00004008);
    op_abort = 1'b1;
    tick();
    op_abort = 1'b0; m_grant = 1'b0;
    check("abort_wr_done", {31'h0, done}, 32'h1);
    check("abort_wr_cnt", {16'h0, xfer_cnt}, 32'h3);
    check("abort_wr_flag", {31'h0, aborted}, 32'h1);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmac_xfer_engine.md
# dmac_xfer_engine

Single-channel DMA transfer engine. It consumes the source address, destination address and word count held in the 32-bit descriptor registers, and moves that many 32-bit words across the shared memory bus as read/write pairs. It sits downstream of the descriptor register bank and upstream of the bus arbiter. Completion is signalled with a done pulse and a sticky interrupt.

## Interface
- CNT_W, 16, width of word count and transfer counter
- clk  in  1  system clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- op_start  in  1  one-cycle start request from the control register write
- op_src  in  32  source byte address (descriptor register output)
- op_dst  in  32  destination byte address (descriptor register output)
- op_size  in  CNT_W  number of 32-bit words to move
- m_req  out  1  bus request
- m_grant  in  1  bus grant; a transaction completes in any cycle where m_req && m_grant
- m_wr  out  1  1 = write, 0 = read
- m_addr  out  32  bus address
- m_dout  out  32  write data
- m_din  in  32  read data, valid in the completing read cycle
- busy  out  1  high in RD and WR
- done  out  1  one-cycle pulse in the DONE state
- irq  out  1  sticky completion interrupt
- irq_clr  in  1  clears irq
- xfer_cnt  out  CNT_W  words written so far in the current or last transfer

## Operation
- States: IDLE, RD, WR, DONE. All state is held in flops and all outputs are decoded from state and registers (Moore style).
- IDLE: op_start=1 latches op_src into src_ptr, op_dst into dst_ptr and op_size into len, and clears xfer_cnt.
  - If op_size != 0, next state is RD.
  - If op_size == 0, next state is DONE.
- RD: m_req=1, m_wr=0, m_addr=src_ptr.
  - On grant, m_din is captured into data_buf and next state is WR.
  - Without grant, the state holds and the address stays stable.
- WR: m_req=1, m_wr=1, m_addr=dst_ptr, m_dout=data_buf.
  - On grant: src_ptr+=4, dst_ptr+=4, xfer_cnt+=1.
  - Next state is DONE if xfer_cnt+1 == len, else RD.
- DONE: done=1 and irq is set. Next state is IDLE.
- op_start outside IDLE is ignored. Latched operands do not change mid-transfer.
- Pointers wrap modulo 2^32; 0xFFFFFFFC+4 = 0x00000000. Unaligned addresses are passed through unchanged.
- irq: set in the DONE cycle, cleared by irq_clr. Simultaneous set and clear: set wins.
- Outside RD/WR, m_req=0, m_wr=0, and m_addr/m_dout=0.

## Timing
- Reset values: state=IDLE, m_req=0, m_wr=0, m_addr=0, m_dout=0, busy=0, done=0, irq=0, xfer_cnt=0. Internal pointers, len and data_buf are also 0.
- Reset asserted mid-transfer aborts immediately with no further bus activity. No done or irq is produced.
- op_start sampled at edge T: m_req is high from cycle T+1.
- With m_grant tied high, N words: done pulses in cycle T+2N+1. For N=0, done pulses in cycle T+1.
- Each wait cycle (m_req=1, m_grant=0) adds exactly one cycle.
- A new op_start is accepted in the cycle after DONE at the earliest.

## Configuration
- DMAC_ABORT_EN defined: adds input op_abort (1 bit) and output aborted (1 bit, reset 0).
  - op_abort sampled high in RD or WR: next state is DONE.
  - If the bus transaction completes in that same cycle, it is honoured: read data is captured, or a write is counted with pointers advanced.
  - aborted is set in DONE when the exit was via abort, and is cleared on the next accepted op_start.
  - done and irq behave normally on abort.
  - op_abort in IDLE or DONE has no effect.
- DMAC_ABORT_EN undefined: neither port exists and a transfer always runs to len words.

## Test plan
- Reset, then src=0x1000, dst=0x2000, size=3, grant tied high -> bus sequence is R1000, W2000, R1004, W2004, R1008, W2008. Write data equals the read data. done is in cycle T+7, xfer_cnt=3, irq=1.
- size=0 -> no m_req, done in cycle T+1, irq=1, xfer_cnt=0.
- Grant withheld 3 cycles on each read, size=2 -> m_addr is stable while waiting and done is in cycle T+11. A second op_start issued during busy is ignored.
- src=0xFFFFFFFC, size=2 -> the second read address is 0x00000000. irq_clr pulsed together with done keeps irq=1; a later irq_clr clears it.
- reset_n pulsed low during WR of word 2 of 4 -> all outputs return to reset values asynchronously, and no done or irq follows.
- With DMAC_ABORT_EN: size=5, op_abort in RD of word 3 without grant -> DONE next cycle, xfer_cnt=2, aborted=1. If the abort coincides with a WR grant, xfer_cnt=3.
